forth_boot_loader: RTL and testbench
====================================

// Module: forth_boot_loader
// PURPOSE
//   Boot loader and instruction store for the forth core. Receives a program image as a byte
//   stream from the host link and writes it into a 1024x16 instruction RAM. Holds the core in
//   reset until a complete image with a valid checksum has been received. Then serves the
//   core's instruction fetches (iaddr -> idata) with the same one-cycle registered latency.
// PARAMETERS
//   DEPTH      1024      instruction words; the address width is log2(DEPTH) = 10
//   NOP_WORD   16'he040  word returned for unloaded addresses and while not running
//   MAGIC      8'ha5     start-of-image byte
// PORTS
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high
//   rx_data    in   8   incoming image byte
//   rx_valid   in   1   rx_data valid
//   rx_ready   out  1   loader accepts a byte; transfer when rx_valid && rx_ready at posedge
//   iaddr      in   10  instruction fetch address from core
//   idata      out  16  instruction word to core, registered
//   cpu_reset  out  1   drives the core reset; 1 until an image is loaded
//   loaded     out  1   1 while in RUN
//   error      out  1   1 while in ERR
// BEHAVIOUR
//   - Reset values: state=HUNT, rx_ready=0 (the cycle reset is high), cpu_reset=1, loaded=0,
//     error=0, idata=NOP_WORD, len=0, word counter=0, checksum=0. RAM contents are not cleared.
//   - Image format: MAGIC, LEN_H, LEN_L (word count N, big-endian), then N words, each sent
//     high byte then low byte, then CSUM = XOR of LEN_H, LEN_L and all data bytes.
//   - rx_ready=1 in every state except RUN and except during reset.
//   - State transitions (each on an accepted byte):
//     - HUNT: MAGIC -> LEN_H; any other byte is discarded.
//     - LEN_H: latch the byte -> LEN_L.
//     - LEN_L: if N==0 or N>DEPTH -> ERR; otherwise clear the word counter -> D_HI.
//     - D_HI: hold the byte -> D_LO.
//     - D_LO: write {hi,lo} to RAM at the word counter and increment it; when the counter
//       reaches N -> CSUM, otherwise -> D_HI.
//     - CSUM: byte == running XOR -> RUN; otherwise -> ERR.
//     - ERR: MAGIC -> LEN_H and clear error; any other byte is discarded.
//     - RUN: terminal; only reset leaves it.
//   - Checksum accumulator clears on MAGIC and XORs in every byte accepted in LEN_H, LEN_L,
//     D_HI and D_LO.
//   - cpu_reset and loaded are registered: cpu_reset falls and loaded rises in the same cycle
//     the state register becomes RUN, i.e. one clock after the CSUM byte is accepted.
//   - Fetch: at each posedge, idata <= (state==RUN && iaddr<len) ? ram[iaddr] : NOP_WORD.
//     Latency is 1 cycle from iaddr to idata, with no stall.
//   - A RAM write is never visible to fetch before RUN, so no read/write collision handling
//     is needed.
//   - Bytes offered while in RUN are left pending (rx_ready=0) and are not consumed.
//   - Reset asserted mid-load aborts the load; the next image must restart with MAGIC.
//     Partially written RAM is harmless because it is only served for iaddr < len in RUN.
//   - Length arithmetic: len is 16 bits wide; the comparison against DEPTH uses the full 16
//     bits; the word counter is 11 bits wide so that it can reach 1024.
// TESTING
//   1. Image A5 00 02 00 01 00 02 CSUM=01 -> rx_ready stays 1 throughout; cpu_reset falls 1
//      cycle after CSUM; iaddr=0 gives idata=0001 next cycle, iaddr=1 gives 0002, iaddr=2
//      gives e040.
//   2. Same image with CSUM=00 -> error=1, cpu_reset stays 1, idata stays e040. Then resend
//      the image with the correct CSUM -> error=0 on MAGIC, and RUN is reached.
//   3. A5 00 00 (length 0) -> ERR. A5 04 01 (length 1025) -> ERR. A5 04 00 with 1024 words
//      and a valid CSUM -> RUN, and iaddr=3ff returns the last word.
//   4. Bytes 12 34 before A5 -> discarded, and the load completes as in test 1. With rx_valid
//      toggled randomly (gaps), the result is identical to test 1.
//   5. Assert reset after the first data word of test 1 -> cpu_reset=1, idata=e040. A fresh
//      image then loads correctly. In RUN, rx_valid=1 with byte A5 -> rx_ready=0, and the
//      state stays RUN.
//   6. Load a program 1 2 ADD (0001 0002 e007) and release the forth core -> the core's TOS
//      is 0003 after its third instruction executes.

Source files
------------

// File: rtl/forth_boot_loader.sv
// rtl/forth_boot_loader.sv - byte-stream image loader and 1-cycle instruction store for the forth core
// Holds the core in reset until a length-checked, checksummed image has been written into RAM.
module forth_boot_loader #(
  parameter int          DEPTH    = 1024,
  parameter logic [15:0] NOP_WORD = 16'he040,
  parameter logic [7:0]  MAGIC    = 8'ha5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [$clog2(DEPTH)-1:0] iaddr,
  output logic [15:0]              idata,
  output logic                     cpu_reset,
  output logic                     loaded,
  output logic                     error
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_HUNT, S_LEN_H, S_LEN_L, S_D_HI, S_D_LO, S_CSUM, S_ERR, S_RUN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_len;
  logic [AW:0]   r_cnt;
  logic [7:0]    r_csum;
  logic [7:0]    r_hi;
  logic [15:0]   r_idata;
  logic          r_cpu_reset;
  logic          r_loaded;
  logic          r_error;
  logic [15:0]   r_ram [DEPTH];

  logic          w_take;
  logic [15:0]   w_len_n;
  logic [AW:0]   w_cnt_inc;

  assign rx_ready  = !reset && (r_state != S_RUN);
  assign w_take    = rx_valid && rx_ready;
  assign w_len_n   = {r_len[15:8], rx_data};
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    if (w_take) begin
      case (r_state)
        S_HUNT, S_ERR: if (rx_data == MAGIC) w_next = S_LEN_H;
        S_LEN_H:       w_next = S_LEN_L;
        S_LEN_L:       w_next = (w_len_n == 16'd0 || w_len_n > DEPTH16) ? S_ERR : S_D_HI;
        S_D_HI:        w_next = S_D_LO;
        S_D_LO:        w_next = ({{(15-AW){1'b0}}, w_cnt_inc} == r_len) ? S_CSUM : S_D_HI;
        S_CSUM:        w_next = (rx_data == r_csum) ? S_RUN : S_ERR;
        default:       w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_len       <= 16'd0;
      r_cnt       <= '0;
      r_csum      <= 8'd0;
      r_hi        <= 8'd0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_reset <= (w_next != S_RUN);
      r_loaded    <= (w_next == S_RUN);
      r_error     <= (w_next == S_ERR);
      if (w_take) begin
        case (r_state)
          S_HUNT, S_ERR: if (rx_data == MAGIC) r_csum <= 8'd0;
          S_LEN_H: begin
            r_len[15:8] <= rx_data;
            r_csum      <= r_csum ^ rx_data;
          end
          S_LEN_L: begin
            r_len[7:0] <= rx_data;
            r_csum     <= r_csum ^ rx_data;
            r_cnt      <= '0;
          end
          S_D_HI: begin
            r_hi   <= rx_data;
            r_csum <= r_csum ^ rx_data;
          end
          S_D_LO: begin
            r_csum <= r_csum ^ rx_data;
            r_cnt  <= w_cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

  // RAM is never cleared; fetch only exposes words below len once in RUN.
  always_ff @(posedge clk) begin
    if (w_take && r_state == S_D_LO) r_ram[r_cnt[AW-1:0]] <= {r_hi, rx_data};
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_idata <= NOP_WORD;
    else if (r_state == S_RUN && {{(16-AW){1'b0}}, iaddr} < r_len)
      r_idata <= r_ram[iaddr];
    else
      r_idata <= NOP_WORD;
  end

  assign idata     = r_idata;
  assign cpu_reset = r_cpu_reset;
  assign loaded    = r_loaded;
  assign error     = r_error;

endmodule

// File: tb/tb_forth_boot_loader.sv
// tb/tb_forth_boot_loader.sv - self-checking bench for forth_boot_loader
module tb_forth_boot_loader;

  localparam logic [15:0] NOP = 16'he040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [9:0]  iaddr = 10'd0;
  logic [15:0] idata;
  logic        cpu_reset;
  logic        loaded;
  logic        error;

  int total = 0;
  int bad = 0;
  int low_ready = 0;
  logic [7:0]  img[$];
  logic [15:0] words[$];

  always #5 clk = ~clk;

  forth_boot_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .iaddr(iaddr), .idata(idata), .cpu_reset(cpu_reset), .loaded(loaded), .error(error)
  );

  // Image = MAGIC, length, words high-then-low, XOR checksum (optionally corrupted).
  task automatic build_image(input int n, input logic [15:0] len_field, input bit corrupt);
    logic [7:0] cs;
    img.delete();
    img.push_back(8'ha5);
    img.push_back(len_field[15:8]);
    img.push_back(len_field[7:0]);
    cs = len_field[15:8] ^ len_field[7:0];
    for (int i = 0; i < n; i++) begin
      img.push_back(words[i][15:8]);
      img.push_back(words[i][7:0]);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
    end
    img.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      else low_ready++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gaps, input string name);
    bit ok;
    bit all_ok = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      send_byte(img[i], gaps, ok);
      if (!ok) all_ok = 1'b0;
    end
    total++;
    if (all_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s: byte handshake timed out (accepted=%0b, required=1)", name, all_ok);
    end
  endtask

  task automatic fetch(input logic [9:0] a, output logic [15:0] d);
    iaddr = a;
    @(posedge clk); #1;
    d = idata;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'ha5;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    reset = 1'b0;
    total++;
    if ({cpu_reset, loaded, error} !== 3'b100) begin
      bad++; $display("FAIL reset_flags: got %b want 100", {cpu_reset, loaded, error});
    end
    total++;
    if (idata !== NOP) begin bad++; $display("FAIL reset_idata: got %h want %h", idata, NOP); end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    logic [15:0] exp [3] = '{16'h0001, 16'h0002, NOP};
    do_reset();
    words = '{16'h0001, 16'h0002};
    build_image(2, 16'd2, 1'b0);
    low_ready = 0;
    send_range(0, img.size() - 2, 1'b0, "basic_body");
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL basic_pre_csum_cpu_reset: got %b want 1", cpu_reset); end
    send_range(img.size() - 1, img.size() - 1, 1'b0, "basic_csum");
    total++;
    if ({cpu_reset, loaded} !== 2'b01) begin
      bad++; $display("FAIL basic_release: got cpu_reset,loaded=%b want 01", {cpu_reset, loaded});
    end
    total++;
    if (low_ready !== 0) begin bad++; $display("FAIL basic_rx_ready_low: got %0d stalls want 0", low_ready); end
    for (int a = 0; a < 3; a++) begin
      fetch(10'(a), d);
      total++;
      if (d !== exp[a]) begin bad++; $display("FAIL basic_fetch[%0d]: got %h want %h", a, d, exp[a]); end
    end
  endtask

  task automatic test_bad_csum();
    logic [15:0] d;
    do_reset();
    words = '{16'h0001, 16'h0002};
    build_image(2, 16'd2, 1'b1);
    send_range(0, img.size() - 1, 1'b0, "badcs_send");
    total++;
    if ({error, cpu_reset, loaded} !== 3'b110) begin
      bad++; $display("FAIL badcs_flags: got %b want 110", {error, cpu_reset, loaded});
    end
    fetch(10'd0, d);
    total++;
    if (d !== NOP) begin bad++; $display("FAIL badcs_fetch: got %h want %h", d, NOP); end
    build_image(2, 16'd2, 1'b0);
    send_range(0, 0, 1'b0, "badcs_magic");
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL badcs_error_clear: got %b want 0", error); end
    send_range(1, img.size() - 1, 1'b0, "badcs_resend");
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL badcs_recover: got loaded=%b want 1", loaded); end
  endtask

  task automatic test_length();
    logic [15:0] d;
    logic [15:0] bad_lens [2] = '{16'd0, 16'd1025};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      img = '{8'ha5, bad_lens[k][15:8], bad_lens[k][7:0]};
      send_range(0, 2, 1'b0, "len_bad_send");
      total++;
      if (error !== 1'b1) begin bad++; $display("FAIL len_bad[%0d]: got error=%b want 1", bad_lens[k], error); end
    end
    do_reset();
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back(16'($urandom));
    build_image(1024, 16'd1024, 1'b0);
    send_range(0, img.size() - 1, 1'b0, "len_max_send");
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL len_max_run: got loaded=%b want 1", loaded); end
    fetch(10'h3ff, d);
    total++;
    if (d !== words[1023]) begin bad++; $display("FAIL len_max_last: got %h want %h", d, words[1023]); end
  endtask

  task automatic test_hunt_gaps();
    logic [15:0] d;
    logic [15:0] exp [3] = '{16'h0001, 16'h0002, NOP};
    do_reset();
    words = '{16'h0001, 16'h0002};
    build_image(2, 16'd2, 1'b0);
    img.push_front(8'h34);
    img.push_front(8'h12);
    send_range(0, img.size() - 1, 1'b1, "hunt_send");
    total++;
    if ({loaded, error} !== 2'b10) begin bad++; $display("FAIL hunt_run: got %b want 10", {loaded, error}); end
    for (int a = 0; a < 3; a++) begin
      fetch(10'(a), d);
      total++;
      if (d !== exp[a]) begin bad++; $display("FAIL hunt_fetch[%0d]: got %h want %h", a, d, exp[a]); end
    end
  endtask

  // Reference: a valid image serves its words below N; anything else serves NOP.
  task automatic test_random();
    logic [15:0] d;
    logic [15:0] exp;
    int n;
    bit corrupt;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 12);
      corrupt = ($urandom_range(0, 2) == 0);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      build_image(n, 16'(n), corrupt);
      for (int j = 0; j < 2; j++) img.push_front(8'($urandom_range(0, 127)));
      do_reset();
      send_range(0, img.size() - 1, 1'b1, "rand_send");
      total++;
      if ({loaded, error} !== {!corrupt, corrupt}) begin
        bad++; $display("FAIL rand_flags it%0d: got %b want %b", it, {loaded, error}, {!corrupt, corrupt});
      end
      for (int a = 0; a < n + 2; a++) begin
        exp = (!corrupt && a < n) ? words[a] : NOP;
        fetch(10'(a), d);
        total++;
        if (d !== exp) begin bad++; $display("FAIL rand_fetch it%0d[%0d]: got %h want %h", it, a, d, exp); end
      end
    end
  endtask

  task automatic test_midreset_run();
    logic [15:0] d;
    do_reset();
    words = '{16'h0001, 16'h0002};
    build_image(2, 16'd2, 1'b0);
    send_range(0, 4, 1'b0, "mid_partial");
    do_reset();
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_cpu_reset: got %b want 1", cpu_reset); end
    fetch(10'd0, d);
    total++;
    if (d !== NOP) begin bad++; $display("FAIL mid_fetch: got %h want %h", d, NOP); end
    send_range(0, img.size() - 1, 1'b0, "mid_fresh");
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL mid_reload: got loaded=%b want 1", loaded); end
    rx_data = 8'ha5;
    rx_valid = 1'b1;
    low_ready = 0;
    repeat (3) begin
      @(negedge clk);
      if (rx_ready === 1'b0) low_ready++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    total++;
    if (low_ready !== 3) begin bad++; $display("FAIL run_rx_ready: got %0d low cycles want 3", low_ready); end
    fetch(10'd1, d);
    total++;
    if ({loaded, d} !== {1'b1, 16'h0002}) begin
      bad++; $display("FAIL run_hold: got loaded=%b idata=%h want 1 0002", loaded, d);
    end
  endtask

  // Stand-in core: literals push, e007 adds the top two stack entries.
  task automatic test_core_program();
    logic [15:0] d;
    logic [15:0] stk[$];
    logic [15:0] a;
    logic [15:0] b;
    do_reset();
    words = '{16'h0001, 16'h0002, 16'he007};
    build_image(3, 16'd3, 1'b0);
    send_range(0, img.size() - 1, 1'b0, "core_load");
    for (int pc = 0; pc < 3; pc++) begin
      fetch(10'(pc), d);
      if (d[15:13] != 3'b111) stk.push_back(d);
      else if (d == 16'he007 && stk.size() >= 2) begin
        a = stk.pop_back();
        b = stk.pop_back();
        stk.push_back(a + b);
      end
    end
    total++;
    if (stk.size() != 1 || stk[0] !== 16'h0003) begin
      bad++; $display("FAIL core_tos: got depth=%0d tos=%h want depth=1 tos=0003", stk.size(),
                      (stk.size() > 0) ? stk[stk.size()-1] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_length();
    test_hunt_gaps();
    test_random();
    test_midreset_run();
    test_core_program();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
